// File: rtl/dsm_sinc3_decimator_if.sv
// Bitstream-in / PCM-out signal bundle for the sinc3 decimator.
// The master side drives the bitstream and the slave side returns decimated samples.
interface dsm_sinc3_decimator_if #(
  parameter int ACC_WIDTH = 17
);
  logic                        i_en;
  logic                        i_data;
  logic signed [ACC_WIDTH-1:0] o_data;
  logic                        o_valid;

  modport master (
    output i_en,
    output i_data,
    input  o_data,
    input  o_valid
  );

  modport slave (
    input  i_en,
    input  i_data,
    output o_data,
    output o_valid
  );
endinterface

// File: rtl/dsm_sinc3_decimator.sv
// Third-order CIC decimator: converts a 1-bit delta-sigma stream into signed PCM.
// It emits one sample every 2^DEC_LOG2 enabled bits.
module dsm_sinc3_decimator #(
  parameter int DEC_LOG2  = 5,
  parameter int ACC_WIDTH = 3*DEC_LOG2+2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  dsm_sinc3_decimator_if.slave bus
);
  localparam logic [DEC_LOG2-1:0] CNT_LAST = {DEC_LOG2{1'b1}};

  logic signed [ACC_WIDTH-1:0] x_s;
  logic signed [ACC_WIDTH-1:0] i1_r, i2_r, i3_r;
  logic signed [ACC_WIDTH-1:0] d1_r, d2_r, d3_r;
  logic signed [ACC_WIDTH-1:0] c1_s, c2_s, c3_s;
  logic signed [ACC_WIDTH-1:0] data_r;
  logic [DEC_LOG2-1:0]         cnt_r;
  logic                        dec_stb_r;
  logic                        valid_r;

  // Map the modulator bit to +1 / -1
  always_comb begin
    x_s = {ACC_WIDTH{1'b1}};
    if (bus.i_data) begin
      x_s = ACC_WIDTH'(1);
    end else begin
      x_s = {ACC_WIDTH{1'b1}};
    end
  end

  // Comb differences over the current delay line
  always_comb begin
    c1_s = i3_r - d1_r;
    c2_s = c1_s - d2_r;
    c3_s = c2_s - d3_r;
  end

  // Integrator chain, decimation counter and strobe; modulo arithmetic wraps by design
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i1_r      <= '0;
      i2_r      <= '0;
      i3_r      <= '0;
      cnt_r     <= '0;
      dec_stb_r <= 1'b0;
    end else if (bus.i_en) begin
      i1_r      <= i1_r + x_s;
      i2_r      <= i2_r + i1_r;
      i3_r      <= i3_r + i2_r;
      cnt_r     <= cnt_r + DEC_LOG2'(1);
      dec_stb_r <= (cnt_r == CNT_LAST);
    end else begin
      dec_stb_r <= 1'b0;
    end
  end

  // Comb delay line and registered output, clocked by the strobe regardless of enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d1_r    <= '0;
      d2_r    <= '0;
      d3_r    <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (dec_stb_r) begin
      d1_r    <= i3_r;
      d2_r    <= c1_s;
      d3_r    <= c2_s;
      data_r  <= c3_s;
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign bus.o_data  = data_r;
  assign bus.o_valid = valid_r;
endmodule

// File: tb/tb_dsm_sinc3_decimator.sv
// Bench for the sinc3 decimator: drives two instances (R=32 and R=8) with the same stream.
// Each instance is compared against a closed-form CIC reference model.
module tb_dsm_sinc3_decimator;
  localparam int LA = 5;
  localparam int LB = 3;
  localparam int WA = 3*LA+2;
  localparam int WB = 3*LB+2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic din   = 1'b0;

  always #5 clk = ~clk;

  dsm_sinc3_decimator_if #(.ACC_WIDTH(WA)) bus_a ();
  dsm_sinc3_decimator_if #(.ACC_WIDTH(WB)) bus_b ();

  assign bus_a.i_en   = en;
  assign bus_a.i_data = din;
  assign bus_b.i_en   = en;
  assign bus_b.i_data = din;

  dsm_sinc3_decimator #(.DEC_LOG2(LA), .ACC_WIDTH(WA)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  dsm_sinc3_decimator #(.DEC_LOG2(LB), .ACC_WIDTH(WB)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  int     checks   = 0;
  int     failures = 0;
  logic   hist [0:4095];
  int     bitcnt;
  longint cyc;
  int     rlog [2];
  int     wid  [2];
  logic   pend [2];
  logic   expv [2];
  int     pulses [2];
  longint lastc  [2];
  longint held   [2];
  longint steady [2];
  bit     steady_on;
  int     stride;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Third integrator value after m accepted bits: sum of x_j * C(m-1-j, 2)
  function automatic longint s3(input int m);
    longint acc;
    acc = 0;
    for (int j = 0; j < m; j++) begin
      acc += (hist[j] ? 64'sd1 : -64'sd1) * longint'((m-1-j)*(m-2-j)/2);
    end
    return acc;
  endfunction

  function automatic longint wrapw(input longint v, input int w);
    longint p;
    longint m;
    p = 64'sd1 <<< w;
    m = v % p;
    if (m < 0) m += p;
    if (m >= p/2) m -= p;
    return m;
  endfunction

  // k-th output: third difference of the integrator sampled at frame ends
  function automatic longint model(input int d, input int k);
    int     r;
    int     n;
    longint y;
    r = 1 << rlog[d];
    n = (k+1)*r;
    y = s3(n) - 3*s3(n-r) + 3*s3(n-2*r) - s3(n-3*r);
    return wrapw(y, wid[d]);
  endfunction

  task automatic step(input logic e, input logic b);
    longint ov [2];
    logic   vv [2];
    string  sfx;
    en  = e;
    din = b;
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) expv[d] = pend[d];
    if (rst_n && en && bitcnt < 4096) begin
      hist[bitcnt] = din;
      bitcnt++;
      for (int d = 0; d < 2; d++) pend[d] = ((bitcnt % (1 << rlog[d])) == 0);
    end else begin
      for (int d = 0; d < 2; d++) pend[d] = 1'b0;
    end
    if (!rst_n) begin
      bitcnt = 0;
      for (int d = 0; d < 2; d++) begin
        pend[d]   = 1'b0;
        expv[d]   = 1'b0;
        pulses[d] = 0;
      end
    end
    @(negedge clk);
    ov[0] = longint'(bus_a.o_data);
    ov[1] = longint'(bus_b.o_data);
    vv[0] = bus_a.o_valid;
    vv[1] = bus_b.o_valid;
    for (int d = 0; d < 2; d++) begin
      sfx = (d == 0) ? "_a" : "_b";
      check_eq({"valid", sfx}, longint'(vv[d]), longint'(expv[d]));
      if (!rst_n) begin
        check_eq({"rst_data", sfx}, ov[d], 0);
      end else if (vv[d]) begin
        check_eq({"sample", sfx}, ov[d], model(d, pulses[d]));
        if (steady_on && pulses[d] >= 3) check_eq({"steady", sfx}, ov[d], steady[d]);
        if (stride > 0 && pulses[d] > 0)
          check_eq({"gap", sfx}, cyc - lastc[d], longint'((1 << rlog[d]) * stride));
        lastc[d] = cyc;
        held[d]  = ov[d];
        pulses[d]++;
      end else if (pulses[d] > 0) begin
        check_eq({"hold", sfx}, ov[d], held[d]);
      end
    end
  endtask

  // Asynchronous assert mid-cycle, outputs must clear with no clock edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_data_a", longint'(bus_a.o_data), 0);
    check_eq("arst_data_b", longint'(bus_b.o_data), 0);
    check_eq("arst_valid_a", longint'(bus_a.o_valid), 0);
    check_eq("arst_valid_b", longint'(bus_b.o_valid), 0);
    @(negedge clk);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  // mode: 0 ones, 1 zeros, 2 alternating, 3 75% duty, 4 random
  task automatic scen(input int mode, input int stride_v, input int ncyc,
                      input longint sa, input longint sb, input bit son);
    logic e;
    logic b;
    do_reset();
    stride    = stride_v;
    steady[0] = sa;
    steady[1] = sb;
    steady_on = son;
    for (int i = 0; i < ncyc; i++) begin
      e = (stride_v == 0) ? ($urandom_range(0, 3) != 0) : ((i % stride_v) == 0);
      case (mode)
        0:       b = 1'b1;
        1:       b = 1'b0;
        2:       b = ((bitcnt % 2) == 0);
        3:       b = ((bitcnt % 4) != 3);
        default: b = ($urandom_range(0, 1) == 1);
      endcase
      step(e, b);
    end
    check_eq("enough_pulses_a", longint'(pulses[0] >= 4), 1);
    check_eq("enough_pulses_b", longint'(pulses[1] >= 4), 1);
  endtask

  initial begin
    rlog[0] = LA;
    rlog[1] = LB;
    wid[0]  = WA;
    wid[1]  = WB;
    bitcnt  = 0;
    cyc     = 0;
    stride  = 0;
    steady_on = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pend[d] = 1'b0; expv[d] = 1'b0; pulses[d] = 0;
      lastc[d] = 0; held[d] = 0; steady[d] = 0;
    end
    @(negedge clk);

    scen(0, 1, 288, 32768, 512, 1'b1);
    scen(1, 1, 288, -32768, -512, 1'b1);
    scen(2, 1, 288, 0, 0, 1'b1);
    scen(3, 1, 288, 16384, 256, 1'b1);
    scen(0, 3, 864, 32768, 512, 1'b1);
    scen(4, 0, 1500, 0, 0, 1'b0);

    // Partial frame followed by reset: the next frame must restart from count 0
    do_reset();
    stride    = 0;
    steady_on = 1'b0;
    for (int i = 0; i < 21; i++) step(1'b1, ($urandom_range(0, 1) == 1));
    scen(4, 0, 600, 0, 0, 1'b0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsm_sinc3_decimator.md
# dsm_sinc3_decimator

Third-order CIC (sinc³) decimation filter that turns the 1-bit delta-sigma bitstream back into signed multi-bit PCM samples. It sits downstream of the integrator/quantizer modulator, on the same clock and enable. It consumes one bit per enabled cycle and emits one full-precision sample every R = 2^DEC_LOG2 enabled bits.

## Interface

Parameters:
- DEC_LOG2, default 5: log2 of decimation ratio R (R = 32 by default); legal range 1..10.
- ACC_WIDTH, default 3*DEC_LOG2+2: width of integrators, combs and output (17 by default); must not be overridden below 3*DEC_LOG2+2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  bitstream qualifier; i_data is consumed only on cycles with i_en=1.
- i_data  in  1  modulator bit; 1 maps to +1, 0 maps to -1.
- o_data  out  ACC_WIDTH  signed decimated sample; holds its value between strobes.
- o_valid  out  1  one-cycle pulse marking a new o_data.

## Operation

- Input mapping: x = +1 when i_data=1, x = -1 when i_data=0, sign-extended to ACC_WIDTH.
- Integrators: three registers I1, I2, I3, all ACC_WIDTH wide. On each enabled edge, I1<=I1+x, I2<=I2+I1, I3<=I3+I2. Every term uses pre-edge values (pipelined chain). No update when i_en=0.
- Wrap rule: integrators and combs use plain two's-complement modulo-2^ACC_WIDTH arithmetic, with no saturation. The final comb result is exact because |output| <= R³ < 2^(ACC_WIDTH-1)+1.
- Decimation counter: DEC_LOG2 bits, counting enabled edges 0..R-1 and wrapping to 0.
- Strobe: the enabled edge at which the counter equals R-1 sets an internal dec_stb register to 1. dec_stb is cleared on the following edge.
- Combs run on edges with dec_stb=1, whatever i_en is:
  - C1 = I3 - D1, C2 = C1 - D2, C3 = C2 - D3, evaluated combinationally.
  - Registered updates: D1<=I3, D2<=C1, D3<=C2, o_data<=C3, o_valid<=1.
- o_valid is cleared on every edge where dec_stb=0.
- Gain: steady-state DC gain is R³, so all-ones input settles to +R³ and all-zeros input settles to -R³.
- Transient: comb delays start at zero after reset. The first 3 output samples are start-up transient; outputs are exact steady-state values from the 4th o_valid onward.

## Timing

- Reset values: I1..I3=0, D1..D3=0, counter=0, dec_stb=0, o_data=0, o_valid=0. Reset is asynchronous assert, synchronous release (release synchronizer lives outside the block).
- Latency: o_valid is high in the cycle beginning 2 edges after the edge that accepts the R-th enabled bit of a frame.
- Output rate: with i_en tied high, o_valid pulses exactly once every R cycles. With gated i_en, it pulses once per R enabled cycles, never two pulses closer than R cycles apart when R>=2.
- i_en low on the edge after the R-th bit: the pending strobe still completes. Combs update and o_valid pulses.
- i_en low at all other times: all state holds and o_valid=0.
- Counter and strobe together: the counter wrap and the comb update may share an edge with a new enabled bit. Both proceed independently; the combs read the pre-edge I3.
- Reset mid-frame: all state, including the partial count, is discarded. The next frame starts at count 0. A pending o_valid is suppressed.
- Throughput: one bit per cycle, with no back-pressure. The consumer must take o_data on the o_valid cycle; o_data stays stable until the next pulse.

## Test plan

- Reset check: assert i_rst_n low mid-stream.
  - Required: o_data=0 and o_valid=0 immediately, with no clock needed.
  - Required after release with R=32: the first o_valid comes 2 edges after the 32nd enabled bit.
- All-ones stream, R=32, i_en=1:
  - Required: o_valid every 32 cycles.
  - Required: o_data = +32768 from the 4th pulse onward.
- All-zeros stream, R=32:
  - Required: o_data = -32768 from the 4th pulse onward. This exercises integrator wrap.
- Alternating 1,0,1,0 stream, R=32:
  - Required: o_data = 0 exactly from the 4th pulse onward.
- Gated enable: all-ones stream with i_en high only on every 3rd cycle.
  - Required: o_valid every 96 cycles.
  - Required: settled o_data = +32768.
  - Required: state does not change on disabled cycles.
- DC ramp: 75% duty stream (1,1,1,0 repeating), R=32.
  - Required: settled o_data = +16384 (mean 0.5 × R³).
  - Repeat with DEC_LOG2=3: settled o_data = +256.
